// File: rtl/input_conditioner_if.sv
// Pin-side bundle between raw board inputs and the conditioned signals
// consumed by the traffic-light FSM/timer.
interface input_conditioner_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] raw_in;
  logic [CHANNELS-1:0] clear;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic [CHANNELS-1:0] sticky_req;

  // Conditioner side.
  modport slave (
    input  raw_in, clear,
    output level_out, rise_pulse, fall_pulse, sticky_req
  );

  // Board/consumer side.
  modport master (
    output raw_in, clear,
    input  level_out, rise_pulse, fall_pulse, sticky_req
  );
endinterface

// File: rtl/input_conditioner.sv
// Per-channel synchroniser, consecutive-sample debounce, edge pulses and a
// sticky "rise seen" request latch for asynchronous controller inputs.
module input_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 Reset,
  input_conditioner_if.slave  io
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync_r [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_r  [CHANNELS];
  logic [CHANNELS-1:0] level_r, rise_r, fall_r, sticky_r;

  logic [CHANNELS-1:0] sync_q, mismatch, accept, accept_rise;

  always_comb begin
    sync_q   = sync_r[SYNC_STAGES-1];
    mismatch = sync_q ^ level_r;
    accept   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      accept[i] = mismatch[i] && (cnt_r[i] == CNT_MAX);
    end
    accept_rise = accept & sync_q;
  end

  // NOTE: all state here uses <= so every flop samples pre-edge values;
  // blocking assignments would collapse the synchroniser chain into one stage.
  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_r[k] <= '0;
      for (int i = 0; i < CHANNELS; i++)    cnt_r[i]  <= '0;
      level_r  <= '0;
      rise_r   <= '0;
      fall_r   <= '0;
      sticky_r <= '0;
    end else begin
      sync_r[0] <= io.raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_r[k] <= sync_r[k-1];

      // Any agreeing sample restarts the run, so short glitches never accumulate.
      for (int i = 0; i < CHANNELS; i++) begin
        if (!mismatch[i] || accept[i]) cnt_r[i] <= '0;
        else                           cnt_r[i] <= cnt_r[i] + 1'b1;
      end

      level_r  <= level_r ^ accept;
      rise_r   <= accept_rise;
      fall_r   <= accept & ~sync_q;
      // Set beats clear so a request arriving with a clear is never lost.
      sticky_r <= accept_rise | (sticky_r & ~io.clear);
    end
  end

  assign io.level_out  = level_r;
  assign io.rise_pulse = rise_r;
  assign io.fall_pulse = fall_r;
  assign io.sticky_req = sticky_r;
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Parametrised front-end for asynchronous controller inputs such as sensor, walk-request and reprogram buttons. Each channel gets:
- a configurable-depth synchroniser chain;
- a consecutive-sample debounce filter;
- rising and falling edge pulses;
- a sticky request latch that holds until the consumer clears it.

It sits between the raw board pins and the traffic-light FSM/timer, and replaces the single-flop per-signal synchroniser.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, flops in each synchroniser chain (>=2)
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised value must differ from level_out before it is accepted (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
raw_in  in  CHANNELS  asynchronous raw inputs, bit i = channel i
clear  in  CHANNELS  per-channel clear of sticky_req (synchronous, from FSM)
level_out  out  CHANNELS  debounced, synchronised level
rise_pulse  out  CHANNELS  one-cycle pulse on accepted 0->1 of level_out
fall_pulse  out  CHANNELS  one-cycle pulse on accepted 1->0 of level_out
sticky_req  out  CHANNELS  latched "rise seen" flag, held until cleared

Behaviour:
- All outputs are registered. There is no combinational path from raw_in or clear to any output.
- Reset (sampled on the clk edge) zeroes everything, regardless of raw_in:
  - all sync flops;
  - all debounce counters;
  - level_out, rise_pulse, fall_pulse and sticky_req.
- Reset overrides every other input in the same cycle.
- Sync chain, per channel: s[0] <= raw_in[i]; s[k] <= s[k-1]. Call the last stage sync_q.
- Debounce counter, per channel:
  - width = max(1, clog2(DEBOUNCE_CYCLES)); it counts consecutive mismatch cycles.
  - If sync_q == level_out: cnt <= 0.
  - If sync_q != level_out and cnt == DEBOUNCE_CYCLES-1: level_out <= sync_q and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - DEBOUNCE_CYCLES=1 means the mismatch is accepted on its first cycle.
- Glitch rejection: a pulse on sync_q shorter than DEBOUNCE_CYCLES cycles never changes level_out, and the counter returns to 0 when the pulse ends.
- Latency: raw_in stable from before edge 1 makes level_out change after edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: 6).
- Edge pulses:
  - On the edge where level_out goes 0->1, rise_pulse is high for exactly the following cycle.
  - On the edge where level_out goes 1->0, fall_pulse is high for exactly the following cycle.
  - Both are 0 in all other cycles.
  - They are never high together on one channel.
- Sticky request:
  - Set on the same edge level_out rises.
  - Cleared on the edge where clear[i]=1 and no rise is being accepted.
  - If a rise and clear[i] coincide, set wins (sticky_req stays/becomes 1), so no request is ever lost.
  - A fall does not affect sticky_req.
- A raw input held high through Reset is treated as a fresh rise after release. rise_pulse fires SYNC_STAGES+DEBOUNCE_CYCLES cycles after the first non-reset edge.
- Reset mid-debounce discards partial count and history; filtering restarts from zero.
- Channels are fully independent. Simultaneous activity on all channels produces correct per-channel results.

Test Plan:
1. Reset=1 for 3 cycles with raw_in=4'hF, clear=0 -> all outputs 0 throughout. After release, level_out=4'hF and rise_pulse=4'hF for one cycle after edge 6, and sticky_req=4'hF.
2. Defaults, raw_in[0] 0->1 stable, clear=0 -> level_out[0]=1 after edge 6, rise_pulse[0]=1 for that single cycle, sticky_req[0]=1 and held. Then raw_in[0]->0 -> fall_pulse[0] one cycle, 6 cycles later; sticky_req[0] stays 1.
3. Glitch rejection on channel 1, with sync_q high measured at the sync output:
   - 3-cycle high pulse -> no change on level_out[1] or rise_pulse[1];
   - 4-cycle high pulse -> level_out[1]=1 and rise_pulse[1] exactly once.
4. Sticky handling on channel 2:
   - clear[2] asserted on the same edge as the accepted rise -> sticky_req[2]=1 after that edge;
   - clear[2] alone one cycle later -> sticky_req[2]=0 next cycle.
5. raw_in[3]=1 for 4 cycles, Reset pulsed for 1 cycle at cycle 4, raw_in held -> level_out[3] rises only after a full 6 clean cycles following reset release.
6. SYNC_STAGES=3, DEBOUNCE_CYCLES=1, CHANNELS=1 -> latency from raw rise to level_out is 4 edges. A 1-cycle raw pulse that reaches sync_q passes as a level change plus rise_pulse.
